// File: rtl/sigmoid_grad.sv
// Sigmoid backprop: delta = err * yc * (1 - yc), yc = y clamped to [0, 1], Q(WIDTH-FL).FL.
// Latency 3 cycles from accept cycle to out_valid; one element in flight, in_ready low until delta is taken.
module sigmoid_grad #(
    parameter int WIDTH = 32,
    parameter int FL    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] delta
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL1 = 2'd1;
    localparam logic [1:0] MUL2 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(64'd1 << FL);

    logic [1:0]                state;
    logic signed [WIDTH-1:0]   yc_q;
    logic signed [WIDTH-1:0]   err_q;
    logic signed [WIDTH-1:0]   t_q;
    logic signed [WIDTH-1:0]   delta_q;

    logic signed [WIDTH-1:0]   yc_in;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   scaled;
    logic                      unused_prod_bits;

    always_comb begin
        yc_in = y;
        if (y < 0) begin
            yc_in = '0;
        end else if (y > ONE) begin
            yc_in = ONE;
        end
    end

    // Single multiplier: yc*(ONE-yc) in MUL1, t*err in MUL2.
    always_comb begin
        mul_a = yc_q;
        mul_b = ONE - yc_q;
        if (state == MUL2) begin
            mul_a = t_q;
            mul_b = err_q;
        end
    end

    assign prod   = mul_a * mul_b;
    // Dropping low bits of a two's-complement product floors toward -infinity.
    assign scaled = prod[FL+WIDTH-1:FL];
    assign unused_prod_bits = ^{prod[FL-1:0], prod[2*WIDTH-1:FL+WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            yc_q    <= '0;
            err_q   <= '0;
            t_q     <= '0;
            delta_q <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        yc_q  <= yc_in;
                        err_q <= err;
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    t_q   <= scaled;
                    state <= MUL2;
                end
                MUL2: begin
                    delta_q <= scaled;
                    state   <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign delta     = delta_q;

endmodule

// File: tb/tb_sigmoid_grad.sv
// Directed bench for sigmoid_grad with hand-computed Q8.24 expected deltas.
module tb_sigmoid_grad;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic [31:0] err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] delta;

    int tests;
    int fails;

    sigmoid_grad #(.WIDTH(32), .FL(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta     (delta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair from IDLE, waits (bounded) for out_valid, then drains it.
    task automatic do_op(input logic [31:0] yv, input logic [31:0] ev,
                         output logic [31:0] got, output int lat);
        y = yv;
        err = ev;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        got = delta;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        y = '0;
        err = '0;
        #12;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        tests++;
        if (delta !== 32'h0) begin
            fails++;
            $display("FAIL reset_delta got=%h want=00000000", delta);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] got;
        int lat;
        do_op(32'h0080_0000, 32'h0100_0000, got, lat);
        tests++;
        if (got !== 32'h0040_0000) begin
            fails++;
            $display("FAIL basic_delta got=%h want=00400000", got);
        end
        tests++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL basic_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] yv [8];
        logic [31:0] ev [8];
        logic [31:0] xv [8];
        logic [31:0] got;
        int lat;
        yv[0] = 32'h0080_0000; ev[0] = 32'hFF00_0000; xv[0] = 32'hFFC0_0000;
        yv[1] = 32'h0100_0000; ev[1] = 32'h0100_0000; xv[1] = 32'h0000_0000;
        yv[2] = 32'hFFB3_3333; ev[2] = 32'h0100_0000; xv[2] = 32'h0000_0000;
        yv[3] = 32'h0120_0000; ev[3] = 32'h0100_0000; xv[3] = 32'h0000_0000;
        yv[4] = 32'h0080_0000; ev[4] = 32'h7FFF_FFFF; xv[4] = 32'h1FFF_FFFF;
        yv[5] = 32'h0040_0000; ev[5] = 32'h0100_0000; xv[5] = 32'h0030_0000;
        yv[6] = 32'h0040_0000; ev[6] = 32'h0000_0001; xv[6] = 32'h0000_0000;
        yv[7] = 32'h0040_0000; ev[7] = 32'hFFFF_FFFF; xv[7] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            do_op(yv[i], ev[i], got, lat);
            tests++;
            if (got !== xv[i]) begin
                fails++;
                $display("FAIL vector%0d y=%h err=%h got=%h want=%h", i, yv[i], ev[i], got, xv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int last_acc;
        int spacing_bad;
        y = 32'h0080_0000;
        err = 32'h0100_0000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        accepts = 0;
        last_acc = -1;
        spacing_bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) begin
                if (last_acc >= 0 && c - last_acc != 4) spacing_bad++;
                last_acc = c;
                accepts++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (accepts !== 3) begin
            fails++;
            $display("FAIL b2b_accepts got=%0d want=3", accepts);
        end
        tests++;
        if (spacing_bad !== 0) begin
            fails++;
            $display("FAIL b2b_spacing bad_gaps=%0d want=0", spacing_bad);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        y = 32'h0080_0000;
        err = 32'h0100_0000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        y = 32'h0040_0000;
        step();
        step();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || delta !== 32'h0040_0000) bad++;
            step();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL bp_hold bad_cycles=%0d want=0 delta=%h", bad, delta);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want=1/0", in_ready, out_valid);
        end
        step();
        step();
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_no_queue out_valid=%b in_ready=%b want=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_enable();
        int lat;
        int bad;
        y = 32'h0080_0000;
        err = 32'h0100_0000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 1;
        en = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            lat++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        en = 1'b1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL en_freeze bad_cycles=%0d want=0", bad);
        end
        tests++;
        if (lat !== 6) begin
            fails++;
            $display("FAIL en_latency got=%0d want=6", lat);
        end
        tests++;
        if (delta !== 32'h0040_0000) begin
            fails++;
            $display("FAIL en_delta got=%h want=00400000", delta);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        y = 32'h0040_0000;
        err = 32'h0100_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || delta !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid in_ready=%b out_valid=%b delta=%h want=1/0/00000000",
                     in_ready, out_valid, delta);
        end
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid !== 1'b0 || delta !== 32'h0) bad++;
        end
        out_ready = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL rst_stale bad_cycles=%0d want=0", bad);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
